// File: rtl/watch_pkg.sv
// Shared types and default timing constants for the watch set controller.
package watch_pkg;

  // Controller modes; TIME is the power-up mode.
  typedef enum logic [1:0] {
    TIME      = 2'd0,
    SET_HOUR  = 2'd1,
    SET_MIN   = 2'd2,
    STOPWATCH = 2'd3
  } watch_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;
  localparam int DEF_TIMEOUT_SEC     = 10;

  // True for the two time-editing modes.
  function automatic logic is_set_state(input watch_state_e s);
    return (s == SET_HOUR) || (s == SET_MIN);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button: 2-FF synchronizer, stability-counter debounce and a
// rising-edge press event. A button already held when reset is released is
// not armed until it has been seen released, so it cannot fake a press.
module btn_conditioner
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;

  // Two-stage synchronizer for the asynchronous pad input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES equal differing samples.
  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    arm_cnt_d = arm_cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = CNT_ZERO;
        press_d = sync2_q & armed_q;
        if (!sync2_q) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
    // Arm once a genuine stable-low period has been observed after reset.
    if (armed_q) begin
      arm_cnt_d = CNT_ZERO;
    end else if (!sync2_q && !level_q) begin
      if (arm_cnt_q == CNT_LAST) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + CNT_ONE;
      end
    end else begin
      arm_cnt_d = CNT_ZERO;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= CNT_ZERO;
      arm_cnt_q <= CNT_ZERO;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/watch_set_controller.sv
// Mode FSM for the watch: turns debounced button presses into clock adjust
// pulses (with auto-repeat), stopwatch run/clear and display/blink selects.
module watch_set_controller
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int TIMEOUT_SEC     = DEF_TIMEOUT_SEC
) (
  input  logic clk,
  input  logic reset,
  input  logic Clk_1sec,
  input  logic mode_btn,
  input  logic set_btn,
  input  logic up_btn,
  input  logic down_btn,
  output logic clock_enable,
  output logic min_inc,
  output logic min_dec,
  output logic hour_inc,
  output logic hour_dec,
  output logic sw_run,
  output logic sw_clear,
  output logic blink_hour,
  output logic blink_min
);

  localparam int RW = $clog2(REPEAT_DELAY) + 1;
  localparam int TW = $clog2(TIMEOUT_SEC) + 1;
  localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] REP_MAX         = {RW{1'b1}};
  localparam logic [RW-1:0] REP_ZERO        = {RW{1'b0}};
  localparam logic [TW-1:0] TO_LAST         = TW'(TIMEOUT_SEC - 1);
  localparam logic [TW-1:0] TO_ZERO         = {TW{1'b0}};

  // Held levels of mode/set are not needed; only their press events matter.
  logic mode_lvl_unused_s, set_lvl_unused_s;
  logic up_lvl_s, dn_lvl_s;
  logic mode_p_s, set_p_s, up_p_s, dn_p_s;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk(clk), .reset(reset), .btn(mode_btn), .level(mode_lvl_unused_s), .press(mode_p_s));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_btn (
    .clk(clk), .reset(reset), .btn(set_btn), .level(set_lvl_unused_s), .press(set_p_s));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_btn (
    .clk(clk), .reset(reset), .btn(up_btn), .level(up_lvl_s), .press(up_p_s));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_btn (
    .clk(clk), .reset(reset), .btn(down_btn), .level(dn_lvl_s), .press(dn_p_s));

  logic          sec_s1_q, sec_s2_q, sec_s3_q;
  logic          tick_s;
  watch_state_e  state_q, state_d;
  logic          rep_active_q, rep_active_d;
  logic          rep_up_q, rep_up_d;
  logic          rep_first_q, rep_first_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          suppress_q, suppress_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          sw_run_q, sw_run_d;
  logic          sw_clear_q, sw_clear_d;
  logic          min_inc_q, min_inc_d, min_dec_q, min_dec_d;
  logic          hour_inc_q, hour_inc_d, hour_dec_q, hour_dec_d;
  logic          clock_enable_q, clock_enable_d;
  logic          blink_hour_q, blink_hour_d, blink_min_q, blink_min_d;

  // Per-cycle decode, written only in the combinational block below.
  logic          in_set_s, any_press_s, both_s, adj_up_s, adj_dn_s;
  logic          timeout_s, trans_s, held_s, fire_s, fire_up_s;
  logic [RW-1:0] rep_target_s;

  // Synchronize the 1 Hz level and detect its rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_s1_q <= 1'b0;
      sec_s2_q <= 1'b0;
      sec_s3_q <= 1'b0;
    end else begin
      sec_s1_q <= Clk_1sec;
      sec_s2_q <= sec_s1_q;
      sec_s3_q <= sec_s2_q;
    end
  end

  assign tick_s = sec_s2_q & ~sec_s3_q;

  // Next state, repeat timer, timeout counter and output decode.
  always_comb begin
    state_d      = state_q;
    rep_active_d = rep_active_q;
    rep_up_d     = rep_up_q;
    rep_first_d  = rep_first_q;
    rep_cnt_d    = rep_cnt_q;
    suppress_d   = suppress_q;
    to_cnt_d     = to_cnt_q;
    sw_run_d     = sw_run_q;
    sw_clear_d   = 1'b0;
    min_inc_d    = 1'b0;
    min_dec_d    = 1'b0;
    hour_inc_d   = 1'b0;
    hour_dec_d   = 1'b0;
    fire_s       = 1'b0;
    fire_up_s    = 1'b0;

    in_set_s     = is_set_state(state_q);
    any_press_s  = mode_p_s | set_p_s | up_p_s | dn_p_s;
    both_s       = up_p_s & dn_p_s;
    adj_up_s     = up_p_s & ~dn_p_s;
    adj_dn_s     = dn_p_s & ~up_p_s;
    timeout_s    = in_set_s & tick_s & (to_cnt_q == TO_LAST) & ~any_press_s;
    held_s       = rep_up_q ? up_lvl_s : dn_lvl_s;
    rep_target_s = rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST;

    // Mode transitions; mode beats set when both arrive together.
    case (state_q)
      TIME: begin
        if (mode_p_s)     state_d = STOPWATCH;
        else if (set_p_s) state_d = SET_HOUR;
        else              state_d = TIME;
      end
      SET_HOUR: begin
        if (mode_p_s)       state_d = TIME;
        else if (set_p_s)   state_d = SET_MIN;
        else if (timeout_s) state_d = TIME;
        else                state_d = SET_HOUR;
      end
      SET_MIN: begin
        if (mode_p_s || set_p_s || timeout_s) state_d = TIME;
        else                                  state_d = SET_MIN;
      end
      STOPWATCH: begin
        if (mode_p_s) state_d = TIME;
        else          state_d = STOPWATCH;
      end
      default: state_d = TIME;
    endcase
    trans_s = (state_d != state_q);

    // Idle-second counter: runs only while editing, cleared by any press.
    if (!in_set_s || any_press_s || timeout_s) begin
      to_cnt_d = TO_ZERO;
    end else if (tick_s) begin
      to_cnt_d = to_cnt_q + TW'(1'b1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    // Up+down together blocks repeat until both buttons are released.
    if (both_s) begin
      suppress_d = 1'b1;
    end else if (!up_lvl_s && !dn_lvl_s) begin
      suppress_d = 1'b0;
    end else begin
      suppress_d = suppress_q;
    end

    // Adjust pulses with auto-repeat; a mode change swallows the press.
    if (in_set_s && !trans_s) begin
      if (adj_up_s || adj_dn_s) begin
        fire_s       = 1'b1;
        fire_up_s    = adj_up_s;
        rep_active_d = 1'b1;
        rep_up_d     = adj_up_s;
        rep_first_d  = 1'b1;
        rep_cnt_d    = REP_ZERO;
      end else if (rep_active_q && !suppress_q && !both_s && held_s) begin
        if (rep_cnt_q == rep_target_s) begin
          fire_s      = 1'b1;
          fire_up_s   = rep_up_q;
          rep_first_d = 1'b0;
          rep_cnt_d   = REP_ZERO;
        end else if (rep_cnt_q != REP_MAX) begin
          rep_cnt_d = rep_cnt_q + RW'(1'b1);
        end else begin
          rep_cnt_d = rep_cnt_q;
        end
      end else begin
        rep_active_d = 1'b0;
      end
    end else begin
      rep_active_d = 1'b0;
    end

    if (fire_s && (state_q == SET_HOUR)) begin
      hour_inc_d = fire_up_s;
      hour_dec_d = ~fire_up_s;
    end else if (fire_s) begin
      min_inc_d = fire_up_s;
      min_dec_d = ~fire_up_s;
    end else begin
      hour_inc_d = 1'b0;
    end

    // Stopwatch: up toggles run, down clears only while stopped.
    if ((state_q == STOPWATCH) && !trans_s) begin
      if (adj_up_s) begin
        sw_run_d = ~sw_run_q;
      end else if (adj_dn_s && !sw_run_q) begin
        sw_clear_d = 1'b1;
      end else begin
        sw_run_d = sw_run_q;
      end
    end else begin
      sw_run_d = sw_run_q;
    end

    clock_enable_d = (state_d != STOPWATCH);
    blink_hour_d   = (state_d == SET_HOUR);
    blink_min_d    = (state_d == SET_MIN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= TIME;
      rep_active_q   <= 1'b0;
      rep_up_q       <= 1'b0;
      rep_first_q    <= 1'b0;
      rep_cnt_q      <= REP_ZERO;
      suppress_q     <= 1'b0;
      to_cnt_q       <= TO_ZERO;
      sw_run_q       <= 1'b0;
      sw_clear_q     <= 1'b0;
      min_inc_q      <= 1'b0;
      min_dec_q      <= 1'b0;
      hour_inc_q     <= 1'b0;
      hour_dec_q     <= 1'b0;
      clock_enable_q <= 1'b1;
      blink_hour_q   <= 1'b0;
      blink_min_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rep_active_q   <= rep_active_d;
      rep_up_q       <= rep_up_d;
      rep_first_q    <= rep_first_d;
      rep_cnt_q      <= rep_cnt_d;
      suppress_q     <= suppress_d;
      to_cnt_q       <= to_cnt_d;
      sw_run_q       <= sw_run_d;
      sw_clear_q     <= sw_clear_d;
      min_inc_q      <= min_inc_d;
      min_dec_q      <= min_dec_d;
      hour_inc_q     <= hour_inc_d;
      hour_dec_q     <= hour_dec_d;
      clock_enable_q <= clock_enable_d;
      blink_hour_q   <= blink_hour_d;
      blink_min_q    <= blink_min_d;
    end
  end

  assign clock_enable = clock_enable_q;
  assign min_inc      = min_inc_q;
  assign min_dec      = min_dec_q;
  assign hour_inc     = hour_inc_q;
  assign hour_dec     = hour_dec_q;
  assign sw_run       = sw_run_q;
  assign sw_clear     = sw_clear_q;
  assign blink_hour   = blink_hour_q;
  assign blink_min    = blink_min_q;

endmodule

// File: tb/tb_watch_set_controller.sv
// Scoreboard bench for watch_set_controller: every expected pulse is queued
// with its cycle when the stimulus is driven and matched when it appears.
module tb_watch_set_controller;

  localparam int D  = 16;
  localparam int RD = 64;
  localparam int RP = 16;
  localparam int B_MODE = 0;
  localparam int B_SET  = 1;
  localparam int B_UP   = 2;
  localparam int B_DOWN = 3;
  localparam logic [4:0] P_MIN_INC  = 5'b00001;
  localparam logic [4:0] P_MIN_DEC  = 5'b00010;
  localparam logic [4:0] P_HOUR_INC = 5'b00100;
  localparam logic [4:0] P_SW_CLR   = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_1sec = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       clock_enable, min_inc, min_dec, hour_inc, hour_dec;
  logic       sw_run, sw_clear, blink_hour, blink_min;
  logic [4:0] pulse_vec;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    logic [4:0] vec;
    int         at;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  watch_set_controller dut (
    .clk(clk), .reset(reset), .Clk_1sec(clk_1sec),
    .mode_btn(btn[B_MODE]), .set_btn(btn[B_SET]), .up_btn(btn[B_UP]), .down_btn(btn[B_DOWN]),
    .clock_enable(clock_enable), .min_inc(min_inc), .min_dec(min_dec),
    .hour_inc(hour_inc), .hour_dec(hour_dec), .sw_run(sw_run), .sw_clear(sw_clear),
    .blink_hour(blink_hour), .blink_min(blink_min)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign pulse_vec = {sw_clear, hour_dec, hour_inc, min_dec, min_inc};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pop one expectation per observed pulse; any unexpected pulse is an error.
  always @(negedge clk) begin
    if (pulse_vec != 5'b00000) begin
      if (sb_q.size() == 0) begin
        check("spurious_pulse", 32'(pulse_vec), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_id", 32'(pulse_vec), 32'(mon_e.vec));
        check("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic expect_pulse(input logic [4:0] v, input int at);
    exp_t e;
    e.vec = v;
    e.at  = at;
    sb_q.push_back(e);
  endtask

  // Hold one button for 'hold' cycles, then release and let it settle.
  task automatic press(input int idx, input int hold);
    btn[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    btn[idx] = 1'b0;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic sec_tick();
    clk_1sec = 1'b1;
    repeat (4) @(negedge clk);
    clk_1sec = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int c;
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_clock_enable", clock_enable, 1);
    check("rst_sw_run", sw_run, 0);
    check("rst_blink", {blink_hour, blink_min}, 0);
    check("rst_pulses", pulse_vec, 0);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // Set press: SET_HOUR exactly 2+D+1 cycles after the raw edge.
    btn[B_SET] = 1'b1;
    repeat (D + 2) @(negedge clk);
    check("blink_hour_early", blink_hour, 0);
    @(negedge clk);
    check("blink_hour_latency", blink_hour, 1);
    repeat (11) @(negedge clk);
    btn[B_SET] = 1'b0;
    repeat (D + 6) @(negedge clk);

    // Up in SET_HOUR: one hour_inc.
    expect_pulse(P_HOUR_INC, cyc + D + 3);
    press(B_UP, 30);
    check("pending_hour_inc", sb_q.size(), 0);

    // Into SET_MIN, then a bouncing up button gives one min_inc.
    press(B_SET, 30);
    check("set_min_blink", {blink_hour, blink_min}, 1);
    for (int i = 0; i < 8; i++) begin
      btn[B_UP] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    expect_pulse(P_MIN_INC, cyc + D + 3);
    press(B_UP, 40);
    check("pending_bounce", sb_q.size(), 0);

    // Down held 200 cycles: pulses at hold offsets 0, RD, RD+RP, ... below 200.
    c = cyc;
    for (int t = 0; t < 200; t = (t == 0) ? RD : t + RP) begin
      expect_pulse(P_MIN_DEC, c + D + 3 + t);
    end
    press(B_DOWN, 200);
    check("pending_repeat", sb_q.size(), 0);

    // Timeout in SET_HOUR.
    press(B_SET, 30);
    press(B_SET, 30);
    check("to_enter_set_hour", blink_hour, 1);
    for (int i = 0; i < 9; i++) sec_tick();
    check("to_after_9", blink_hour, 1);
    expect_pulse(P_HOUR_INC, cyc + D + 3);
    press(B_UP, 30);
    sec_tick();
    check("to_press_restarts", blink_hour, 1);
    for (int i = 0; i < 8; i++) sec_tick();
    check("to_before_limit", blink_hour, 1);
    sec_tick();
    check("to_exit_state", {clock_enable, blink_hour, blink_min}, 3'b100);

    // Stopwatch run/clear.
    press(B_MODE, 30);
    check("sw_display", clock_enable, 0);
    press(B_UP, 30);
    check("sw_run_on", sw_run, 1);
    press(B_DOWN, 30);
    check("sw_run_kept", sw_run, 1);
    press(B_UP, 30);
    check("sw_run_off", sw_run, 0);
    expect_pulse(P_SW_CLR, cyc + D + 3);
    press(B_DOWN, 30);
    check("pending_sw_clear", sb_q.size(), 0);
    press(B_MODE, 30);
    check("sw_exit_display", clock_enable, 1);
    check("sw_run_after_exit", sw_run, 0);

    // Up and down together in SET_HOUR for 300 cycles: no adjust pulse.
    press(B_SET, 30);
    btn[B_UP]   = 1'b1;
    btn[B_DOWN] = 1'b1;
    repeat (300) @(negedge clk);
    btn[B_UP]   = 1'b0;
    btn[B_DOWN] = 1'b0;
    repeat (D + 6) @(negedge clk);
    check("both_stay_set_hour", blink_hour, 1);
    expect_pulse(P_HOUR_INC, cyc + D + 3);
    press(B_UP, 30);
    check("pending_after_both", sb_q.size(), 0);

    // Mode and set together: mode wins, back to TIME.
    btn[B_MODE] = 1'b1;
    press(B_SET, 30);
    btn[B_MODE] = 1'b0;
    repeat (D + 6) @(negedge clk);
    check("mode_wins", {clock_enable, blink_hour, blink_min}, 3'b100);

    // Reset during an auto-repeat hold.
    press(B_SET, 30);
    c = cyc;
    expect_pulse(P_HOUR_INC, c + D + 3);
    expect_pulse(P_HOUR_INC, c + D + 3 + RD);
    btn[B_UP] = 1'b1;
    repeat (D + 3 + RD) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("reset_drops_pulse", hour_inc, 0);
    check("reset_state", {clock_enable, blink_hour}, 2'b10);
    btn[B_SET] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("held_set_not_press", blink_hour, 0);
    btn[B_UP]  = 1'b0;
    btn[B_SET] = 1'b0;
    repeat (D + 6) @(negedge clk);
    press(B_SET, 30);
    check("set_after_release", blink_hour, 1);
    check("pending_final", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
